// File: rtl/zone_avg_feeder.sv
// zone_avg_feeder: accumulates one screen zone's RGB sums and pixel count, issues
// R/G/B divide requests to the downstream divider and publishes the zone average.
module zone_avg_feeder #(
    parameter int PIX_W   = 8,
    parameter int N       = 17,
    parameter int M       = 10,
    parameter int CNT_MAX = (1 << (N - PIX_W)) - 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic             pix_in_zone,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    input  logic             zone_end,
    output logic             div_data_rdy,
    output logic [N-1:0]     div_dividend,
    output logic [M-1:0]     div_divisor,
    input  logic             div_res_rdy,
    input  logic [N-1:0]     div_merchant,
    output logic             avg_valid,
    output logic [PIX_W-1:0] avg_r,
    output logic [PIX_W-1:0] avg_g,
    output logic [PIX_W-1:0] avg_b,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [2:0] {
        ACC,
        ISS_R,
        ISS_G,
        ISS_B,
        WAIT,
        OUT
    } state_t;

    localparam int           EXT_W     = N - PIX_W;
    localparam logic [M-1:0] CNT_LIMIT = M'(CNT_MAX);

    state_t       state;
    state_t       next_state;
    logic [N-1:0] sum_r;
    logic [N-1:0] sum_g;
    logic [N-1:0] sum_b;
    logic [M-1:0] count;
    logic [1:0]   res_cnt;
    logic         ovf_q;

    logic         pix_hit;
    logic         room;
    logic         zone_empty;
    logic [N-1:0] ext_r;
    logic [N-1:0] ext_g;
    logic [N-1:0] ext_b;

    assign pix_hit = pix_valid & pix_in_zone;
    assign room    = (count < CNT_LIMIT);
    assign ext_r   = {{EXT_W{1'b0}}, pix_r};
    assign ext_g   = {{EXT_W{1'b0}}, pix_g};
    assign ext_b   = {{EXT_W{1'b0}}, pix_b};

    // Zone is empty when the count after this cycle (same-cycle pixel included) is zero.
    assign zone_empty = frame_start ? !pix_hit : ((count == '0) && !pix_hit);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACC: begin
                if (zone_end) begin
                    next_state = zone_empty ? OUT : ISS_R;
                end
            end
            ISS_R:   next_state = ISS_G;
            ISS_G:   next_state = ISS_B;
            ISS_B:   next_state = WAIT;
            WAIT: begin
                if (div_res_rdy && (res_cnt == 2'd2)) begin
                    next_state = OUT;
                end
            end
            OUT:     next_state = ACC;
            default: next_state = ACC;
        endcase
    end

    always_comb begin
        div_data_rdy = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        avg_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            ACC: busy = 1'b0;
            ISS_R: begin
                div_data_rdy = 1'b1;
                div_dividend = sum_r;
                div_divisor  = count;
            end
            ISS_G: begin
                div_data_rdy = 1'b1;
                div_dividend = sum_g;
                div_divisor  = count;
            end
            ISS_B: begin
                div_data_rdy = 1'b1;
                div_dividend = sum_b;
                div_divisor  = count;
            end
            OUT:     avg_valid = 1'b1;
            default: ;
        endcase
    end

    // Sums and count only move in ACC; they hold through the divide and clear on OUT exit.
    always_ff @(posedge clk) begin
        if (rstn) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (frame_start) begin
                        ovf_q <= 1'b0;
                        if (pix_hit) begin
                            sum_r <= ext_r;
                            sum_g <= ext_g;
                            sum_b <= ext_b;
                            count <= M'(1);
                        end else begin
                            sum_r <= '0;
                            sum_g <= '0;
                            sum_b <= '0;
                            count <= '0;
                        end
                    end else if (pix_hit) begin
                        if (room) begin
                            sum_r <= sum_r + ext_r;
                            sum_g <= sum_g + ext_g;
                            sum_b <= sum_b + ext_b;
                            count <= count + M'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    sum_r <= '0;
                    sum_g <= '0;
                    sum_b <= '0;
                    count <= '0;
                    ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Results are matched to channels purely by arrival order, so only WAIT may advance this.
    always_ff @(posedge clk) begin
        if (rstn) begin
            res_cnt <= '0;
        end else if (state == OUT) begin
            res_cnt <= '0;
        end else if ((state == WAIT) && div_res_rdy) begin
            res_cnt <= res_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            avg_r <= '0;
            avg_g <= '0;
            avg_b <= '0;
        end else if ((state == ACC) && zone_end && zone_empty) begin
            avg_r <= '0;
            avg_g <= '0;
            avg_b <= '0;
        end else if ((state == WAIT) && div_res_rdy) begin
            case (res_cnt)
                2'd0:    avg_r <= div_merchant[PIX_W-1:0];
                2'd1:    avg_g <= div_merchant[PIX_W-1:0];
                2'd2:    avg_b <= div_merchant[PIX_W-1:0];
                default: ;
            endcase
        end
    end

    assign overflow = ovf_q;

endmodule

// File: doc/zone_avg_feeder.md
# zone_avg_feeder

Collects per-zone RGB channel sums and the in-zone pixel count for one screen zone of the background-LED pipeline. At zone end it issues three divide requests (R, G, B) back-to-back into the pipelined divider that sits directly downstream. It then gathers the three quotients and presents the zone's average colour, one pulse per zone, to the LED driver stage.

## Interface
- PIX_W, 8, width of each colour channel
- N, 17, channel-sum width and divider dividend/quotient width
- M, 10, pixel-count and divider divisor width
- CNT_MAX, 2^(N-PIX_W)-1 (511), maximum accepted pixels per zone; keeps sums within N bits

- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous, active-high reset: rstn=1 at a clk edge resets the block
- frame_start  in  1  pulse; clears accumulators when in ACC
- pix_valid  in  1  pixel present this cycle
- pix_in_zone  in  1  pixel belongs to this zone
- pix_r / pix_g / pix_b  in  PIX_W each  pixel channels
- zone_end  in  1  pulse; last pixel of the zone has been presented (this cycle included)
- div_data_rdy  out  1  divider request strobe, one cycle per request
- div_dividend  out  N  channel sum for the current request
- div_divisor  out  M  pixel count
- div_res_rdy  in  1  divider result strobe
- div_merchant  in  N  divider quotient
- avg_valid  out  1  one-cycle pulse; averages valid
- avg_r / avg_g / avg_b  out  PIX_W each  zone averages, held until the next avg_valid
- busy  out  1  high in every state except ACC
- overflow  out  1  sticky per zone: at least one in-zone pixel was dropped at CNT_MAX

## Operation
- States: ACC, ISS_R, ISS_G, ISS_B, WAIT, OUT. Reset state is ACC.
- Reset values: all outputs 0, sums 0, count 0, result counter 0.
- ACC behaviour:
  - Each cycle with pix_valid & pix_in_zone & count<CNT_MAX: sum_r/g/b += pixel, count += 1.
  - An accepted pixel with count==CNT_MAX is dropped and sets overflow.
- frame_start in ACC clears sums, count and overflow.
  - If frame_start and a valid pixel arrive in the same cycle, the pixel becomes the first sample: sums = pixel, count = 1.
  - frame_start outside ACC is ignored.
- zone_end in ACC:
  - The same-cycle pixel is included.
  - Next state is ISS_R, or OUT if the final count is 0.
- zone_end outside ACC is ignored.
- ISS_R, ISS_G, ISS_B:
  - div_data_rdy=1, div_dividend = sum of that channel, div_divisor = count.
  - Sequence is ISS_R→ISS_G→ISS_B→WAIT, one cycle each, no stall.
- WAIT:
  - Count div_res_rdy pulses 0,1,2 and capture div_merchant[PIX_W-1:0] into avg_r, avg_g, avg_b in that order. Upper quotient bits are 0 by construction.
  - The third pulse moves the state to OUT.
- OUT:
  - avg_valid=1 for one cycle.
  - If count was 0, avg_r/g/b = 0 and no requests are issued.
  - On exit: sums, count, result counter and overflow are cleared; state returns to ACC.
- overflow is readable until the OUT exit clears it.
- Pixels arriving while busy=1 are dropped without setting overflow.
- Reset mid-operation aborts everything and returns to ACC with cleared state. Divider results still in flight after reset are ignored, because the result counter only advances in WAIT.

## Timing
- zone_end sampled at cycle t. div_data_rdy is high at t+1, t+2 and t+3 (R, G, B).
- Divider latency L = N cycles (17 by default). div_res_rdy arrives at t+1+L, t+2+L, t+3+L.
- avg_valid at t+4+L (t+21 by default). Back in ACC, busy=0, at t+5+L.
- Zero-count zone: OUT at t+1 with avg_valid=1; ACC at t+2.
- The block does not assume L: it counts res_rdy pulses. div_res_rdy pulses outside WAIT are ignored.
- div_dividend and div_divisor are 0 whenever div_data_rdy=0.

## Test plan
- Zone of 4 pixels (10,20,30), (20,40,60), (30,60,90), (40,80,120), zone_end on the last pixel → dividends 100, 200, 300 with divisor 4 at t+1..t+3; avg = (25,50,75) at t+4+L; overflow=0.
- Zone of 3 pixels with R sums 0+0+2 → avg_r=0 (truncating division); pixels with pix_in_zone=0 in the stream are not counted.
- Zone end with no in-zone pixels → no div_data_rdy; avg_valid at t+1 with (0,0,0).
- 600 in-zone pixels of (255,255,255) → count saturates at 511, overflow=1, dividend 130305, avg = (255,255,255).
- Pixels and a second zone_end during WAIT → ignored; no extra div_data_rdy; next zone starts from zero sums.
- Assert rstn for one cycle in WAIT after 1 result → all outputs 0; late div_res_rdy pulses produce no avg_valid; next zone averages correctly.
